// File: rtl/arbitro_memoria_datos_pkg.sv
// Shared definitions for the data-memory arbiter and users of memoria_datos:
// word width, word-index slice and the arbiter FSM encoding.
package pkg_memoria;

   localparam int WORD_W  = 64;
   localparam int IDX_LSB = 2;
   localparam int IDX_MSB = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } estado_arb_t;

   // Out of range when the word index runs past the memory or any upper address bit is set.
   function automatic logic fuera_rango(input logic [WORD_W-1:0] a, input int unsigned depth);
      return ({2'b00, a[IDX_MSB:IDX_LSB]} >= 32'(depth)) || (a[WORD_W-1:IDX_MSB+1] != '0);
   endfunction

endpackage

// File: rtl/arbitro_memoria_datos_selector_rr.sv
// Two-input round-robin picker; the history bit is owned by the caller.
module selector_rr (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_idx
);

   assign grant_valid = |req;
   // On a tie the requester that was not served last wins.
   assign grant_idx   = (&req) ? ~last : req[1];

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Round-robin arbiter and single-access sequencer in front of memoria_datos.
// Every transaction is IDLE -> ACCESS -> ACK, one memory cycle each.
module arbitro_memoria_datos
   import pkg_memoria::*;
#(
   parameter int DEPTH = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [WORD_W-1:0] addr0,
   input  logic [WORD_W-1:0] addr1,
   input  logic [WORD_W-1:0] wdata0,
   input  logic [WORD_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err,
   output logic [WORD_W-1:0] rdata,
   output logic              busy,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_a,
   output logic [WORD_W-1:0] mem_wd,
   input  logic [WORD_W-1:0] mem_rd
);

   estado_arb_t       state_q;
   logic              we_q, oor_q, sel_q, last_q;
   logic [WORD_W-1:0] addr_q, wd_q, rdata_q;

   logic              grant_valid, grant_idx;
   logic              we_sel;
   logic [WORD_W-1:0] addr_sel, wd_sel;

   selector_rr u_sel (
      .req         ({req1, req0}),
      .last        (last_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign we_sel   = grant_idx ? we1    : we0;
   assign addr_sel = grant_idx ? addr1  : addr0;
   assign wd_sel   = grant_idx ? wdata1 : wdata0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         oor_q   <= 1'b0;
         sel_q   <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         wd_q    <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  we_q    <= we_sel;
                  addr_q  <= addr_sel;
                  wd_q    <= wd_sel;
                  sel_q   <= grant_idx;
                  oor_q   <= fuera_rango(addr_sel, DEPTH);
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               // Reads of an out-of-range word return zero rather than aliased data.
               rdata_q <= oor_q ? '0 : mem_rd;
               last_q  <= sel_q;
               state_q <= ACK;
            end
            ACK:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack0   = (state_q == ACK) && !sel_q;
   assign ack1   = (state_q == ACK) &&  sel_q;
   assign err    = (state_q == ACK) &&  oor_q;
   assign rdata  = rdata_q;
   assign busy   = (state_q != IDLE);
   // Reset gates the strobe combinationally so an aborted access never commits.
   assign mem_we = (state_q == ACCESS) && we_q && !oor_q && !reset;
   assign mem_a  = addr_q;
   assign mem_wd = wd_q;

endmodule
